// File: rtl/mandel_frame_sequencer.sv
// mandel_frame_sequencer
//   Takes the HPS PIO parameter words, waits for them to stop changing, then
//   walks every pixel of the frame in raster order and hands each pixel's
//   screen and fixed-point complex coordinate to the iterator cores over a
//   valid/ready handshake. Completed pixels are counted and the frame-done
//   flag (plus optional render cycle count) is reported back to the HPS.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   cr_initial, ci_initial           complex coordinate of pixel (0,0)
//   step_r, step_i                   per-x real / per-y imaginary increment
//   max_iterations                   iteration cap, forwarded per pixel
//   pix_valid/pix_ready              pixel descriptor handshake
//   pix_x, pix_y, pix_cr, pix_ci     pixel descriptor
//   pix_max_iter                     iteration cap latched at frame start
//   done_valid                       one pulse per finished pixel
//   reset_mandel                     bit 0: 1-cycle core restart pulse
//   finish_render                    bit 31: frame done, 30:0: cycle count
//
// Build option
//   MANDEL_CYCLE_COUNT_EN: when defined, finish_render[30:0] carries a
//   saturating count of EMIT+DRAIN cycles; otherwise those bits read 0.
module mandel_frame_sequencer #(
  parameter int H_PIXELS      = 640,
  parameter int V_PIXELS      = 480,
  parameter int COORD_W       = 27,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        cr_initial,
  input  logic [31:0]        ci_initial,
  input  logic [31:0]        step_r,
  input  logic [31:0]        step_i,
  input  logic [31:0]        max_iterations,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic [COORD_W-1:0] pix_cr,
  output logic [COORD_W-1:0] pix_ci,
  output logic [31:0]        pix_max_iter,
  input  logic               done_valid,
  output logic [31:0]        reset_mandel,
  output logic [31:0]        finish_render
);

  typedef enum logic [2:0] {S_SETTLE, S_START, S_EMIT, S_DRAIN, S_DONE} state_t;

  localparam logic [9:0]  X_LAST      = 10'(H_PIXELS - 1);
  localparam logic [8:0]  Y_LAST      = 9'(V_PIXELS - 1);
  localparam logic [18:0] TOTAL       = 19'(H_PIXELS * V_PIXELS);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_t             state;
  logic               init_q;     // forces a "change" on the first cycle after reset
  logic [31:0]        sh_cr, sh_ci, sh_sr, sh_si, sh_mi;
  logic [31:0]        settle_cnt;
  logic [COORD_W-1:0] cr0, step_r_q, step_i_q;
  logic [18:0]        done_cnt;
  logic               done_flag;
  logic               rst_pulse;

  logic               param_chg;
  logic               done_en;
  logic [18:0]        done_cnt_nxt;

  // Full 32-bit compare: upper PIO bits are ignored for arithmetic but a
  // write to them still restarts the frame.
  assign param_chg = init_q ||
                     (cr_initial     != sh_cr) || (ci_initial != sh_ci) ||
                     (step_r         != sh_sr) || (step_i     != sh_si) ||
                     (max_iterations != sh_mi);

  assign done_en      = done_valid && (state == S_EMIT || state == S_DRAIN);
  assign done_cnt_nxt = (done_en && done_cnt < TOTAL) ? done_cnt + 19'd1 : done_cnt;

  assign reset_mandel = {31'd0, rst_pulse};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_SETTLE;
      init_q       <= 1'b1;
      sh_cr        <= '0;
      sh_ci        <= '0;
      sh_sr        <= '0;
      sh_si        <= '0;
      sh_mi        <= '0;
      settle_cnt   <= '0;
      cr0          <= '0;
      step_r_q     <= '0;
      step_i_q     <= '0;
      done_cnt     <= '0;
      done_flag    <= 1'b0;
      rst_pulse    <= 1'b0;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_cr       <= '0;
      pix_ci       <= '0;
      pix_max_iter <= '0;
    end else begin
      init_q    <= 1'b0;
      rst_pulse <= 1'b0;
      if (param_chg) begin
        // Abort whatever is in flight; pix_valid drops regardless of ready.
        sh_cr      <= cr_initial;
        sh_ci      <= ci_initial;
        sh_sr      <= step_r;
        sh_si      <= step_i;
        sh_mi      <= max_iterations;
        settle_cnt <= '0;
        pix_valid  <= 1'b0;
        done_flag  <= 1'b0;
        state      <= S_SETTLE;
      end else begin
        case (state)
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              rst_pulse <= 1'b1;        // high for the START cycle only
              done_flag <= 1'b0;
              state     <= S_START;
            end else begin
              settle_cnt <= settle_cnt + 32'd1;
            end
          end
          S_START: begin
            cr0          <= sh_cr[COORD_W-1:0];
            step_r_q     <= sh_sr[COORD_W-1:0];
            step_i_q     <= sh_si[COORD_W-1:0];
            pix_max_iter <= sh_mi;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_cr       <= sh_cr[COORD_W-1:0];
            pix_ci       <= sh_ci[COORD_W-1:0];
            done_cnt     <= '0;
            pix_valid    <= 1'b1;
            state        <= S_EMIT;
          end
          S_EMIT: begin
            done_cnt <= done_cnt_nxt;
            if (pix_ready) begin
              if (pix_x != X_LAST) begin
                pix_x  <= pix_x + 10'd1;
                pix_cr <= pix_cr + step_r_q;
              end else if (pix_y != Y_LAST) begin
                pix_x  <= '0;
                pix_cr <= cr0;
                pix_y  <= pix_y + 9'd1;
                pix_ci <= pix_ci + step_i_q;
              end else begin
                // Last pixel taken: coordinates stay on (H-1,V-1).
                pix_valid <= 1'b0;
                state     <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            done_cnt <= done_cnt_nxt;
            if (done_cnt_nxt == TOTAL) begin
              done_flag <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE:  ;
          default: state <= S_SETTLE;
        endcase
      end
    end
  end

`ifdef MANDEL_CYCLE_COUNT_EN
  logic [30:0] cyc_cnt;

  // Counts EMIT and DRAIN cycles; stops by itself once the FSM sits in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cyc_cnt <= '0;
    else if (state == S_START)
      cyc_cnt <= '0;
    else if ((state == S_EMIT || state == S_DRAIN) && cyc_cnt != '1)
      cyc_cnt <= cyc_cnt + 31'd1;
  end

  assign finish_render = {done_flag, cyc_cnt};
`else
  assign finish_render = {done_flag, 31'd0};
`endif

endmodule

// File: tb/tb_mandel_frame_sequencer.sv
`timescale 1ns/1ps
module tb_mandel_frame_sequencer;

`ifdef MANDEL_CYCLE_COUNT_EN
  localparam logic [31:0] EXP_FIN = 32'h8000000F;
`else
  localparam logic [31:0] EXP_FIN = 32'h80000000;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Shared parameter words
  logic [31:0] cr_i, ci_i, sr_i, si_i, mi_i;

  // Small instance: 4x3, settle 4
  logic        s_valid, s_ready, s_done;
  logic [9:0]  s_x;
  logic [8:0]  s_y;
  logic [26:0] s_cr, s_ci;
  logic [31:0] s_mi, s_rm, s_fin;

  // Large instance: 640x480, settle 8
  logic        b_valid, b_ready, b_done;
  logic [9:0]  b_x;
  logic [8:0]  b_y;
  logic [26:0] b_cr, b_ci;
  logic [31:0] b_mi, b_rm, b_fin;

  // done_valid model: each accepted pixel completes 3 cycles later
  logic [2:0] acc_pipe = 3'b000;
  logic       done_auto, done_extra;
  always @(posedge clk) acc_pipe <= {acc_pipe[1:0], s_valid && s_ready};
  assign s_done = (done_auto && acc_pipe[2]) || done_extra;
  assign b_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mandel_frame_sequencer #(.H_PIXELS(4), .V_PIXELS(3), .COORD_W(27), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cr_initial(cr_i), .ci_initial(ci_i), .step_r(sr_i), .step_i(si_i), .max_iterations(mi_i),
    .pix_valid(s_valid), .pix_ready(s_ready), .pix_x(s_x), .pix_y(s_y),
    .pix_cr(s_cr), .pix_ci(s_ci), .pix_max_iter(s_mi),
    .done_valid(s_done), .reset_mandel(s_rm), .finish_render(s_fin));

  mandel_frame_sequencer #(.H_PIXELS(640), .V_PIXELS(480), .COORD_W(27), .SETTLE_CYCLES(8)) dut_big (
    .clk(clk), .reset_n(reset_n),
    .cr_initial(cr_i), .ci_initial(ci_i), .step_r(sr_i), .step_i(si_i), .max_iterations(mi_i),
    .pix_valid(b_valid), .pix_ready(b_ready), .pix_x(b_x), .pix_y(b_y),
    .pix_cr(b_cr), .pix_ci(b_ci), .pix_max_iter(b_mi),
    .done_valid(b_done), .reset_mandel(b_rm), .finish_render(b_fin));

  task automatic test_reset();
    reset_n = 1'b0; s_ready = 1'b0; b_ready = 1'b0; done_auto = 1'b0; done_extra = 1'b0;
    cr_i = 32'h0700_0000; ci_i = 32'h0780_0000; sr_i = 32'h100; si_i = 32'h200; mi_i = 32'd100;
    repeat (3) @(negedge clk);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", s_valid); end
    n_checks++; if ({s_x, s_y} !== 19'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 0,0", s_x, s_y); end
    n_checks++; if ({s_cr, s_ci} !== 54'd0) begin n_fail++; $display("FAIL reset_coord: got %h,%h want 0,0", s_cr, s_ci); end
    n_checks++; if (s_mi !== 32'd0) begin n_fail++; $display("FAIL reset_maxiter: got %h want 0", s_mi); end
    n_checks++; if (s_rm !== 32'd0) begin n_fail++; $display("FAIL reset_rm: got %h want 0", s_rm); end
    n_checks++; if (s_fin !== 32'd0) begin n_fail++; $display("FAIL reset_fin: got %h want 0", s_fin); end
    n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_big_valid: got %b want 0", b_valid); end
  endtask

  task automatic test_start_latency();
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_checks++; if ({s_rm[0], s_valid} !== 2'b00) begin n_fail++; $display("FAIL lat_settle: got rm=%b v=%b want 0,0", s_rm[0], s_valid); end
      end
      if (i == 5) begin
        n_checks++; if ({s_rm, s_valid} !== {32'd1, 1'b0}) begin n_fail++; $display("FAIL lat_start: got rm=%h v=%b want 1,0", s_rm, s_valid); end
      end
      if (i == 6) begin
        n_checks++; if ({s_valid, s_rm[0]} !== 2'b10) begin n_fail++; $display("FAIL lat_emit: got v=%b rm=%b want 1,0", s_valid, s_rm[0]); end
        n_checks++; if ({s_cr, s_ci} !== {27'h7000000, 27'h7800000}) begin n_fail++; $display("FAIL lat_coord: got %h,%h want 7000000,7800000", s_cr, s_ci); end
        n_checks++; if (s_mi !== 32'd100) begin n_fail++; $display("FAIL lat_maxiter: got %0d want 100", s_mi); end
      end
      if (i == 9) begin
        n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL lat_big_early: got %b want 0", b_valid); end
      end
      if (i == 10) begin
        n_checks++; if ({b_valid, b_x, b_y} !== {1'b1, 10'd0, 9'd0}) begin n_fail++; $display("FAIL lat_big: got v=%b %0d,%0d want 1 0,0", b_valid, b_x, b_y); end
      end
    end
  endtask

  task automatic test_raster();
    b_ready = 1'b1;
    n_checks++; if (b_cr !== 27'h7000000) begin n_fail++; $display("FAIL raster_0_0: got %h want 7000000", b_cr); end
    for (int k = 1; k <= 1930; k++) begin
      @(negedge clk);
      if (k == 639) begin
        n_checks++; if ({b_x, b_y, b_cr} !== {10'd639, 9'd0, 27'h7027F00}) begin n_fail++; $display("FAIL raster_639_0: got %0d,%0d cr=%h want 639,0 7027F00", b_x, b_y, b_cr); end
      end
      if (k == 640) begin
        n_checks++; if ({b_x, b_y, b_cr, b_ci} !== {10'd0, 9'd1, 27'h7000000, 27'h7800200}) begin n_fail++; $display("FAIL raster_0_1: got %0d,%0d cr=%h ci=%h want 0,1 7000000 7800200", b_x, b_y, b_cr, b_ci); end
      end
    end
    b_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({b_valid, b_x, b_y, b_cr, b_ci} !== {1'b1, 10'd10, 9'd3, 27'h7000A00, 27'h7800600}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b %0d,%0d cr=%h ci=%h want 1 10,3 7000A00 7800600", k, b_valid, b_x, b_y, b_cr, b_ci);
      end
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    n_checks++; if ({b_valid, b_x, b_y, b_cr} !== {1'b1, 10'd11, 9'd3, 27'h7000B00}) begin n_fail++; $display("FAIL bp_next: got v=%b %0d,%0d cr=%h want 1 11,3 7000B00", b_valid, b_x, b_y, b_cr); end
  endtask

  task automatic test_completion();
    mi_i = 32'd200; s_ready = 1'b1; done_auto = 1'b1;
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      if (j == 5) begin
        n_checks++; if ({s_rm[0], s_valid} !== 2'b10) begin n_fail++; $display("FAIL cmp_start: got rm=%b v=%b want 1,0", s_rm[0], s_valid); end
      end
      if (j == 6) begin
        n_checks++; if ({s_valid, s_x, s_y, s_mi} !== {1'b1, 10'd0, 9'd0, 32'd200}) begin n_fail++; $display("FAIL cmp_first: got v=%b %0d,%0d mi=%0d want 1 0,0 200", s_valid, s_x, s_y, s_mi); end
      end
      if (j == 10) begin
        n_checks++; if ({s_x, s_y, s_cr, s_ci} !== {10'd0, 9'd1, 27'h7000000, 27'h7800200}) begin n_fail++; $display("FAIL cmp_wrap: got %0d,%0d cr=%h ci=%h want 0,1 7000000 7800200", s_x, s_y, s_cr, s_ci); end
      end
      if (j == 17) begin
        n_checks++; if ({s_x, s_y, s_cr, s_ci} !== {10'd3, 9'd2, 27'h7000300, 27'h7800400}) begin n_fail++; $display("FAIL cmp_last: got %0d,%0d cr=%h ci=%h want 3,2 7000300 7800400", s_x, s_y, s_cr, s_ci); end
      end
      if (j == 18) begin
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL cmp_drain: got v=%b want 0", s_valid); end
      end
      if (j == 20) begin
        n_checks++; if (s_fin[31] !== 1'b0) begin n_fail++; $display("FAIL cmp_early_done: got %b want 0", s_fin[31]); end
      end
      if (j == 21) begin
        n_checks++; if (s_fin !== EXP_FIN) begin n_fail++; $display("FAIL cmp_finish: got %h want %h", s_fin, EXP_FIN); end
      end
    end
    done_auto = 1'b0; done_extra = 1'b1;
    @(negedge clk);
    done_extra = 1'b0;
    @(negedge clk);
    n_checks++; if (s_fin !== EXP_FIN) begin n_fail++; $display("FAIL cmp_extra_pulse: got %h want %h", s_fin, EXP_FIN); end
  endtask

  task automatic test_midframe_change();
    sr_i = 32'h180;
    for (int j = 1; j <= 12; j++) @(negedge clk);
    n_checks++; if ({s_valid, s_x, s_y, s_cr, s_ci} !== {1'b1, 10'd2, 9'd1, 27'h7000300, 27'h7800200}) begin n_fail++; $display("FAIL mid_pos: got v=%b %0d,%0d cr=%h ci=%h want 1 2,1 7000300 7800200", s_valid, s_x, s_y, s_cr, s_ci); end
    sr_i = 32'h100; s_ready = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) begin
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_abort: got v=%b want 0", s_valid); end
      end
      if (j == 4) begin
        n_checks++; if (s_rm !== 32'd0) begin n_fail++; $display("FAIL mid_rm_early: got %h want 0", s_rm); end
      end
      if (j == 5) begin
        n_checks++; if (s_rm !== 32'd1) begin n_fail++; $display("FAIL mid_rm_pulse: got %h want 1", s_rm); end
      end
      if (j == 6) begin
        n_checks++; if ({s_valid, s_x, s_y, s_cr, s_rm[0], s_fin[31]} !== {1'b1, 10'd0, 9'd0, 27'h7000000, 2'b00}) begin
          n_fail++; $display("FAIL mid_restart: got v=%b %0d,%0d cr=%h rm=%b fin31=%b want 1 0,0 7000000 0 0", s_valid, s_x, s_y, s_cr, s_rm[0], s_fin[31]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    s_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({s_valid, s_x} !== {1'b1, 10'd3}) begin n_fail++; $display("FAIL ar_pre: got v=%b x=%0d want 1 3", s_valid, s_x); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({s_valid, s_x, s_y, s_cr, s_ci, s_mi, s_rm, s_fin} !== 151'd0) begin
      n_fail++; $display("FAIL ar_async: got v=%b %0d,%0d cr=%h ci=%h mi=%h rm=%h fin=%h want all 0", s_valid, s_x, s_y, s_cr, s_ci, s_mi, s_rm, s_fin);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1; done_auto = 1'b1;
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      if (j == 5) begin
        n_checks++; if (s_rm !== 32'd1) begin n_fail++; $display("FAIL ar_rm: got %h want 1", s_rm); end
      end
      if (j == 6) begin
        n_checks++; if ({s_valid, s_x, s_y, s_cr} !== {1'b1, 10'd0, 9'd0, 27'h7000000}) begin n_fail++; $display("FAIL ar_first: got v=%b %0d,%0d cr=%h want 1 0,0 7000000", s_valid, s_x, s_y, s_cr); end
      end
      if (j == 21) begin
        n_checks++; if (s_fin !== EXP_FIN) begin n_fail++; $display("FAIL ar_finish: got %h want %h", s_fin, EXP_FIN); end
      end
    end
    done_auto = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_raster();
    test_backpressure();
    test_completion();
    test_midframe_change();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_frame_sequencer.md
# mandel_frame_sequencer

Frame sequencer directly downstream of the HPS PIO exports (`cr_initial`, `ci_initial`, `step_r`, `step_i`, `max_iterations`) and upstream of the Mandelbrot iterator cores. It detects and settles new parameter writes from the HPS, then restarts the frame and walks every pixel in raster order. For each pixel it emits the screen coordinate and the fixed-point complex coordinate over a valid/ready handshake. It counts completed pixels and drives the `finish_render` and `reset_mandel` words back to the HPS.

## Interface
Parameters:
- `H_PIXELS`, 640, pixels per row
- `V_PIXELS`, 480, rows per frame
- `COORD_W`, 27, signed fixed-point width in 4.23 format, taken from PIO bits `[COORD_W-1:0]`
- `SETTLE_CYCLES`, 1024, number of cycles the parameters must stay unchanged before a render starts

Ports (clock and reset first):
- `clk`  in  1  the single clock; all logic uses the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cr_initial`  in  32  real coordinate of pixel (0,0)
- `ci_initial`  in  32  imaginary coordinate of pixel (0,0)
- `step_r`  in  32  real increment per x
- `step_i`  in  32  imaginary increment per y
- `max_iterations`  in  32  iteration cap, passed through per pixel
- `pix_valid`  out  1  pixel descriptor valid
- `pix_ready`  in  1  downstream accepts the descriptor
- `pix_x`  out  10  pixel column
- `pix_y`  out  9  pixel row
- `pix_cr`  out  COORD_W  pixel real coordinate
- `pix_ci`  out  COORD_W  pixel imaginary coordinate
- `pix_max_iter`  out  32  latched iteration cap
- `done_valid`  in  1  one pulse per completed pixel
- `reset_mandel`  out  32  bit 0 is a 1-cycle restart pulse; bits 31:1 are 0
- `finish_render`  out  32  bit 31 is the frame-done flag; bits 30:0 are the render cycle count (see Configuration)

## Operation
- Shadow registers hold the last sampled value of the five parameter words. Any difference between input and shadow:
  - reloads the shadow registers;
  - clears the settle counter;
  - enters SETTLE from any state.
- Deassertion of reset counts as a parameter change, so the first frame renders with no HPS write.
- States:
  - SETTLE: settle counter increments. At SETTLE_CYCLES-1 → START.
  - START (1 cycle):
    - latch `cr0`/`ci0`/steps/max_iter;
    - x=y=0; cr=cr0, ci=ci0;
    - clear the done count, the cycle count and `finish_render[31]`;
    - `reset_mandel[0]`=1 for this cycle only;
    - → EMIT.
  - EMIT: `pix_valid`=1. On `pix_valid&&pix_ready`:
    - if x<H_PIXELS-1: x+=1, cr+=step_r;
    - otherwise: x=0, cr=cr0, y+=1, ci+=step_i.
    - Acceptance of pixel (H-1, V-1) → DRAIN.
  - DRAIN: `pix_valid`=0. Wait for the done count to reach H_PIXELS*V_PIXELS.
  - DONE: `finish_render[31]`=1. Hold until the next parameter change.
- Done count is 19 bits. It increments on `done_valid` in EMIT and DRAIN only; `done_valid` is ignored in SETTLE, START and DONE. The count saturates at H*V. When it reaches H*V in DRAIN, the state → DONE on the next edge.
- Arithmetic: cr/ci add in two's complement modulo 2^COORD_W; wrap-around is permitted, with no saturation. PIO bits above COORD_W are ignored for coordinates but still participate in change detection.
- A parameter change in EMIT or DRAIN aborts the frame:
  - `pix_valid` drops on the next edge, even when `pix_ready` is low;
  - outstanding `done_valid` pulses are discarded;
  - `reset_mandel` flushes the cores at the next START.

## Timing
- Reset value of every output: `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_cr`=0, `pix_ci`=0, `pix_max_iter`=0, `reset_mandel`=0, `finish_render`=0.
- The first render starts SETTLE_CYCLES+1 cycles after reset release; `pix_valid` rises on the following cycle.
- Throughput is 1 pixel/cycle while `pix_ready`=1.
- While `pix_valid`=1 and `pix_ready`=0, all `pix_*` outputs are held stable.
- Parameter change to first `pix_valid`: SETTLE_CYCLES+2 cycles.
- Pixel acceptance and `done_valid` in the same cycle are both honoured.

## Configuration
- `MANDEL_CYCLE_COUNT_EN` defined:
  - a 31-bit counter clears in START and increments every cycle in EMIT and DRAIN;
  - it saturates at 2^31-1 and freezes on entry to DONE;
  - `finish_render[30:0]` shows the counter live.
- Macro undefined: `finish_render[30:0]` is tied to 0 and no counter is synthesised.

## Test plan
- Raster walk: H=640, V=480, cr_initial=0x07000000 (-2.0), ci_initial=0x07800000 (-1.0), step_r=0x100, step_i=0x200, `pix_ready`=1. Required:
  - pixel (0,0): cr=0x7000000;
  - pixel (639,0): cr=0x7027F00;
  - pixel (0,1): cr=0x7000000, ci=0x7800200.
- Backpressure: drop `pix_ready` for 5 cycles at pixel (10,3). Required: x, y, cr, ci and `pix_valid` are unchanged for all 5 cycles, then (11,3) follows on the cycle after acceptance.
- Completion, with H=4, V=3, SETTLE_CYCLES=4 and the macro defined:
  - 12 accepts with 12 `done_valid` pulses, the last one 3 cycles after the final accept;
  - required: `finish_render`=0x8000000F (12 EMIT + 3 DRAIN cycles);
  - a 13th pulse in DONE leaves `finish_render` unchanged.
- Mid-frame change: write `step_r` during EMIT at pixel (2,1). Required:
  - `pix_valid`=0 next cycle;
  - after SETTLE_CYCLES, a 1-cycle `reset_mandel`=1;
  - the new frame restarts at (0,0) with `finish_render[31]`=0.
- Async reset: assert `reset_n`=0 mid-EMIT. Required: all outputs are 0 immediately, without waiting for a clock edge, and a full frame restarts after release.
- Macro undefined: the completion test above gives `finish_render`=0x80000000.
